load_unit: RTL and testbench
============================

Name: load_unit

Overview:
- Sequential load-side counterpart of the store merge path in the multicycle MIPS datapath.
- On a start command it holds a memory read request until memory signals ready, then captures the returned word into an internal MDR.
- Extracts the word, byte or halfword lane and zero- or sign-extends it to 32 bits for register writeback.
- Includes a watchdog timeout so a stalled memory never hangs the control FSM.

Parameters:
- TIMEOUT, 16: maximum number of WAIT cycles before the request is abandoned. Legal range 2..255.
- CNT_W, 8: width of the wait counter. Must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  load command, sampled only in IDLE.
- LoadCtrl  input  2  load size: 00 word, 01 byte, 10 halfword, 11 reserved (treated as word). Sampled with start.
- sign_ext  input  1  1 = sign-extend, 0 = zero-extend. Sampled with start; ignored for word loads.
- mem_rdata  input  32  memory read data, valid when mem_ready=1.
- mem_ready  input  1  memory read-complete strobe.
- mem_rd  output  1  memory read request.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse (success or timeout).
- err  output  1  one-cycle timeout pulse, coincident with done.
- mdr_out  output  32  raw captured memory word.
- ld_out  output  32  extracted and extended load result.

Behaviour:
- Reset (asynchronous, active-high): state = IDLE. mem_rd, busy, done, err = 0. mdr_out = 0, ld_out = 0, wait counter = 0, latched LoadCtrl and sign_ext = 0. Reset mid-transaction abandons the request; mem_rd drops immediately.
- States are IDLE, WAIT, DONE and ERR.
- IDLE:
  - start=1 latches LoadCtrl and sign_ext, clears the counter and moves to WAIT.
  - start=0 stays in IDLE.
- WAIT:
  - mem_rd=1 and busy=1.
  - mem_ready=1: mdr_out <= mem_rdata, ld_out <= extract(mem_rdata), then move to DONE.
  - Otherwise the counter increments. If counter == TIMEOUT-1 with mem_ready=0, move to ERR.
  - mem_ready on the final counted cycle wins over timeout.
- DONE: done=1, mem_rd=0, busy=1 for exactly one cycle, then IDLE.
- ERR: done=1, err=1, mem_rd=0 for one cycle, then IDLE. mdr_out and ld_out keep their previous values.
- start outside IDLE is ignored. Changes to LoadCtrl or sign_ext after start have no effect on the transaction in flight.
- mem_ready outside WAIT is ignored and nothing is captured.
- Latency: start at cycle N → mem_rd first high at N+1. mem_ready at cycle M (M ≥ N+1) → done and valid ld_out at M+1. Minimum start-to-done is 2 cycles. The next start is accepted 1 cycle after done (IDLE).
- Lane extraction (matches the store merge lane placement):
  - Word: ld_out = mem_rdata[31:0].
  - Byte: lane = mem_rdata[31:24]; ld_out = {24 x fill, lane}.
  - Halfword: lane = mem_rdata[31:16]; ld_out = {16 x fill, lane}.
  - fill = sign_ext ? lane MSB : 0.
- Outputs are registered, with no combinational path from mem_rdata to ld_out. mdr_out and ld_out hold their value until the next successful capture.

Test Plan:
- Reset: assert reset asynchronously mid-WAIT → all outputs 0 immediately, state IDLE; mem_ready afterwards ignored.
- Word: start with LoadCtrl=00; mem_ready asserted 3 cycles after mem_rd rises, mem_rdata=32'hDEADBEEF → done pulse 1 cycle later, ld_out=mdr_out=32'hDEADBEEF, err=0.
- Byte: LoadCtrl=01, mem_rdata=32'h80FF1234:
  - sign_ext=1 → ld_out=32'hFFFFFF80.
  - sign_ext=0 → ld_out=32'h00000080.
  - mdr_out=32'h80FF1234 in both cases.
- Half: LoadCtrl=10, mem_rdata=32'h7FFFABCD, sign_ext=1 → ld_out=32'h00007FFF. Repeat with mem_rdata=32'h8001ABCD → ld_out=32'hFFFF8001.
- Timeout: TIMEOUT=16, mem_ready held 0 → mem_rd high exactly 16 cycles, then done=err=1 for one cycle; ld_out unchanged. Repeat with mem_ready on the 16th WAIT cycle → normal DONE, err=0.
- Protocol: pulse start during WAIT and DONE → no second transaction. Change LoadCtrl mid-WAIT → extraction uses the latched value. mem_ready pulse in IDLE → mdr_out unchanged. Back-to-back: start the cycle after done → accepted.

Source files
------------

// File: rtl/load_unit_if.sv
// Load unit command/memory/result bundle.
// slave = load unit side, master = controller + memory side.
interface load_unit_if;
  logic        start;
  logic [1:0]  LoadCtrl;
  logic        sign_ext;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        mem_rd;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] mdr_out;
  logic [31:0] ld_out;

  modport slave (
    input  start, LoadCtrl, sign_ext, mem_rdata, mem_ready,
    output mem_rd, busy, done, err, mdr_out, ld_out
  );

  modport master (
    output start, LoadCtrl, sign_ext, mem_rdata, mem_ready,
    input  mem_rd, busy, done, err, mdr_out, ld_out
  );
endinterface

// File: rtl/load_unit.sv
// Multicycle load: holds mem_rd until mem_ready (or watchdog), captures MDR and extended lane; done 1 cycle after mem_ready.
// Memory backpressure is mem_ready; start is only accepted while idle, so callers wait for done.
module load_unit #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  load_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic        sext_q, sext_d;
  logic [31:0] mdr_q, mdr_d;
  logic [31:0] ld_q, ld_d;
  logic [31:0] ext;
  logic        fill;

  // Byte and halfword lanes both sit at the top of the word, so the sign bit is always bit 31.
  always_comb begin
    fill = sext_q & bus.mem_rdata[31];
    ext  = bus.mem_rdata;
    case (ctrl_q)
      2'b01:   ext = {{24{fill}}, bus.mem_rdata[31:24]};
      2'b10:   ext = {{16{fill}}, bus.mem_rdata[31:16]};
      default: ext = bus.mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl_d  = ctrl_q;
    sext_d  = sext_q;
    mdr_d   = mdr_q;
    ld_d    = ld_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          ctrl_d  = bus.LoadCtrl;
          sext_d  = bus.sign_ext;
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A ready on the last counted cycle still completes normally.
        if (bus.mem_ready) begin
          mdr_d   = bus.mem_rdata;
          ld_d    = ext;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ctrl_q  <= 2'b00;
      sext_q  <= 1'b0;
      mdr_q   <= 32'h0;
      ld_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
      sext_q  <= sext_d;
      mdr_q   <= mdr_d;
      ld_q    <= ld_d;
    end
  end

  // Status outputs are pure decodes of the state register, so reset clears them immediately.
  assign bus.mem_rd  = (state_q == S_WAIT);
  assign bus.busy    = (state_q != S_IDLE);
  assign bus.done    = (state_q == S_DONE) || (state_q == S_ERR);
  assign bus.err     = (state_q == S_ERR);
  assign bus.mdr_out = mdr_q;
  assign bus.ld_out  = ld_q;

endmodule

// File: tb/tb_load_unit.sv
// Bench for load_unit: directed vector table, protocol/reset sequences, randomized loads vs reference model.
module tb_load_unit;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  load_unit_if bus();

  load_unit #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_mdr = 32'h0;
  logic [31:0] exp_ld = 32'h0;

  typedef struct {
    logic [1:0]  c;
    logic        s;
    logic [31:0] d;
    int          dly;
    logic [31:0] e_ld;
    logic [31:0] e_mdr;
    logic        e_err;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Reference extraction done arithmetically: shift by division, sign by range test.
  function automatic logic [31:0] ref_ld(input logic [1:0] c, input logic s, input logic [31:0] d);
    logic [31:0] lane;
    if (c == 2'd1) begin
      lane = d / 32'h0100_0000;
      if (s && lane >= 32'd128) return lane + 32'hFFFF_FF00;
      return lane;
    end
    if (c == 2'd2) begin
      lane = d / 32'h0001_0000;
      if (s && lane >= 32'd32768) return lane + 32'hFFFF_0000;
      return lane;
    end
    return d;
  endfunction

  // Issues one load; memory answers on WAIT cycle dly+1 (never if dly >= TO).
  // Returns at the negedge where done is high. LoadCtrl/sign_ext are inverted after start.
  task automatic do_load(input logic [1:0] c, input logic s, input logic [31:0] d,
                         input int dly, input logic poke,
                         output logic got_done, output logic got_err, output int rd_cycles);
    int k;
    @(negedge clk);
    bus.start = 1'b1;
    bus.LoadCtrl = c;
    bus.sign_ext = s;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    bus.LoadCtrl = ~c;
    bus.sign_ext = ~s;
    rd_cycles = 0;
    k = 0;
    while (!bus.done && k < 100) begin
      if (bus.mem_rd) begin
        rd_cycles++;
        bus.start = poke;
        if (rd_cycles == dly + 1) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = d;
        end else begin
          bus.mem_ready = 1'b0;
          bus.mem_rdata = $urandom;
        end
      end else begin
        bus.mem_ready = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    got_done = bus.done;
    got_err = bus.err;
    bus.mem_ready = 1'b0;
    if (k >= 100) begin
      checks++;
      failures++;
      $display("FAIL done_wait expired after %0d cycles, done=%b required 1", k, bus.done);
    end
  endtask

  task automatic check_result(input string tag, input logic gd, input logic ge, input int rd,
                              input int dly, input logic e_err,
                              input logic [31:0] e_ld, input logic [31:0] e_mdr);
    chk({tag, "_done"}, 32'(gd), 32'd1);
    chk({tag, "_err"}, 32'(ge), 32'(e_err));
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    chk({tag, "_rd_cycles"}, 32'(rd), e_err ? 32'(TO) : 32'(dly + 1));
    chk({tag, "_ld_out"}, bus.ld_out, e_ld);
    chk({tag, "_mdr_out"}, bus.mdr_out, e_mdr);
  endtask

  initial begin
    logic gd, ge;
    int rd;
    logic [1:0] rc;
    logic rs;
    logic [31:0] rdat;
    int rdly;

    bus.start = 1'b0;
    bus.LoadCtrl = 2'b00;
    bus.sign_ext = 1'b0;
    bus.mem_rdata = 32'h0;
    bus.mem_ready = 1'b0;

    tbl[0] = '{2'b00, 1'b0, 32'hDEADBEEF, 3,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
    tbl[1] = '{2'b01, 1'b1, 32'h80FF1234, 1,  32'hFFFFFF80, 32'h80FF1234, 1'b0};
    tbl[2] = '{2'b01, 1'b0, 32'h80FF1234, 0,  32'h00000080, 32'h80FF1234, 1'b0};
    tbl[3] = '{2'b10, 1'b1, 32'h7FFFABCD, 2,  32'h00007FFF, 32'h7FFFABCD, 1'b0};
    tbl[4] = '{2'b10, 1'b1, 32'h8001ABCD, 5,  32'hFFFF8001, 32'h8001ABCD, 1'b0};
    tbl[5] = '{2'b11, 1'b1, 32'h8001ABCD, 0,  32'h8001ABCD, 32'h8001ABCD, 1'b0};
    tbl[6] = '{2'b00, 1'b0, 32'h12345678, 15, 32'h12345678, 32'h12345678, 1'b0};
    tbl[7] = '{2'b10, 1'b0, 32'h8001ABCD, 20, 32'h12345678, 32'h12345678, 1'b1};
    tbl[8] = '{2'b01, 1'b0, 32'hFF00AA55, 1,  32'h000000FF, 32'hFF00AA55, 1'b0};
    tbl[9] = '{2'b10, 1'b0, 32'hC0015555, 4,  32'h0000C001, 32'hC0015555, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_mdr", bus.mdr_out, 32'h0);
    chk("rst_ld", bus.ld_out, 32'h0);
    reset = 1'b0;

    // Directed vectors, back-to-back (each start lands in the IDLE cycle after done)
    for (int i = 0; i < 10; i++) begin
      do_load(tbl[i].c, tbl[i].s, tbl[i].d, tbl[i].dly, 1'b0, gd, ge, rd);
      check_result($sformatf("vec%0d", i), gd, ge, rd, tbl[i].dly, tbl[i].e_err,
                   tbl[i].e_ld, tbl[i].e_mdr);
    end
    exp_mdr = 32'hC0015555;
    exp_ld = 32'h0000C001;

    // start held high through WAIT and DONE must not launch a second transaction
    do_load(2'b10, 1'b1, 32'h8001ABCD, 4, 1'b1, gd, ge, rd);
    check_result("poke", gd, ge, rd, 4, 1'b0, 32'hFFFF8001, 32'h8001ABCD);
    exp_mdr = 32'h8001ABCD;
    exp_ld = 32'hFFFF8001;
    @(negedge clk);
    bus.start = 1'b0;
    chk("poke_idle_busy", 32'(bus.busy), 32'd0);
    chk("poke_idle_mem_rd", 32'(bus.mem_rd), 32'd0);
    @(negedge clk);
    chk("poke_idle_busy2", 32'(bus.busy), 32'd0);

    // mem_ready while idle is ignored
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h11111111;
    repeat (2) @(negedge clk);
    bus.mem_ready = 1'b0;
    chk("idle_ready_mdr", bus.mdr_out, exp_mdr);
    chk("idle_ready_ld", bus.ld_out, exp_ld);
    chk("idle_ready_done", 32'(bus.done), 32'd0);

    // Asynchronous reset mid-WAIT
    bus.start = 1'b1;
    bus.LoadCtrl = 2'b00;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    chk("midwait_mem_rd", 32'(bus.mem_rd), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_mem_rd", 32'(bus.mem_rd), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_mdr", bus.mdr_out, 32'h0);
    chk("arst_ld", bus.ld_out, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hAAAA5555;
    repeat (2) @(negedge clk);
    bus.mem_ready = 1'b0;
    chk("post_rst_mdr", bus.mdr_out, 32'h0);
    chk("post_rst_done", 32'(bus.done), 32'd0);
    chk("post_rst_busy", 32'(bus.busy), 32'd0);
    exp_mdr = 32'h0;
    exp_ld = 32'h0;

    // Randomized loads against the reference model
    for (int n = 0; n < 40; n++) begin
      rc = 2'($urandom_range(0, 3));
      rs = 1'($urandom_range(0, 1));
      rdat = $urandom;
      rdly = $urandom_range(0, 19);
      do_load(rc, rs, rdat, rdly, 1'($urandom_range(0, 1)), gd, ge, rd);
      if (rdly < TO) begin
        exp_mdr = rdat;
        exp_ld = ref_ld(rc, rs, rdat);
      end
      check_result($sformatf("rnd%0d", n), gd, ge, rd, rdly, rdly >= TO, exp_ld, exp_mdr);
      bus.start = 1'b0;
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
